// File: rtl/hazard_control_unit_if.sv
// Decode/Execute boundary signals between the pipeline and the hazard control unit.
// The pipeline side uses master and the hazard unit uses slave.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             decode_valid;
    logic [3:0]       rs1_decode;
    logic [3:0]       rs2_decode;
    logic             uses_rs1_decode;
    logic             uses_rs2_decode;
    logic [3:0]       rd_decode;
    logic             wre_decode;
    logic             vector_op_decode;
    logic [3:0]       rd_execute;
    logic             wre_execute;
    logic             load_instruction;
    logic [3:0]       rd_memory;
    logic             wre_memory;
    logic             branch_taken_execute;

    logic             stall_fetch;
    logic             stall_decode;
    logic             nop_mux_select;
    logic             flush_decode;
    logic [1:0]       forwardA_sel;
    logic [1:0]       forwardB_sel;
    logic             vec_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output decode_valid, rs1_decode, rs2_decode, uses_rs1_decode, uses_rs2_decode,
               rd_decode, wre_decode, vector_op_decode, rd_execute, wre_execute,
               load_instruction, rd_memory, wre_memory, branch_taken_execute,
        input  stall_fetch, stall_decode, nop_mux_select, flush_decode,
               forwardA_sel, forwardB_sel, vec_busy, stall_cycles
    );

    modport slave (
        input  decode_valid, rs1_decode, rs2_decode, uses_rs1_decode, uses_rs2_decode,
               rd_decode, wre_decode, vector_op_decode, rd_execute, wre_execute,
               load_instruction, rd_memory, wre_memory, branch_taken_execute,
        output stall_fetch, stall_decode, nop_mux_select, flush_decode,
               forwardA_sel, forwardB_sel, vec_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller for the 16-bit pipeline: load-use and vector
// scoreboard stalls, branch flush, and forwarding selects registered into execute.
module hazard_control_unit #(
    parameter int VEC_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave bus
);
    localparam int VW = $clog2(VEC_LATENCY + 1);

    logic [VW-1:0]    r_vec_cnt;
    logic [3:0]       r_vec_rd;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_m1_ex, w_m2_ex, w_m1_mem, w_m2_mem, w_m1_vec, w_m2_vec;
    logic w_load_haz, w_vec_haz, w_vec_busy;
    logic w_stall, w_nop, w_flush, w_issue;
    logic [1:0] w_fwd_a_next, w_fwd_b_next;

    function automatic logic src_match(input logic used, input logic [3:0] src,
                                       input logic [3:0] dst);
        return used && (src == dst);
    endfunction

    assign w_m1_ex  = src_match(bus.uses_rs1_decode, bus.rs1_decode, bus.rd_execute);
    assign w_m2_ex  = src_match(bus.uses_rs2_decode, bus.rs2_decode, bus.rd_execute);
    assign w_m1_mem = src_match(bus.uses_rs1_decode, bus.rs1_decode, bus.rd_memory);
    assign w_m2_mem = src_match(bus.uses_rs2_decode, bus.rs2_decode, bus.rd_memory);
    assign w_m1_vec = src_match(bus.uses_rs1_decode, bus.rs1_decode, r_vec_rd);
    assign w_m2_vec = src_match(bus.uses_rs2_decode, bus.rs2_decode, r_vec_rd);

    assign w_vec_busy = (r_vec_cnt != '0);

    assign w_load_haz = bus.decode_valid && bus.load_instruction && bus.wre_execute
                        && (w_m1_ex || w_m2_ex);

    // A busy vector unit blocks readers and writers of its destination and any new vector op.
    assign w_vec_haz = bus.decode_valid && w_vec_busy
                       && (w_m1_vec || w_m2_vec
                           || (bus.wre_decode && (bus.rd_decode == r_vec_rd))
                           || bus.vector_op_decode);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        w_stall = 1'b0;
        w_nop   = 1'b0;
        w_flush = 1'b0;
        if (!reset) begin
            w_nop = 1'b1;
        end else if (bus.branch_taken_execute) begin
            w_flush = 1'b1;
            w_nop   = 1'b1;
        end else if (w_load_haz || w_vec_haz) begin
            w_stall = 1'b1;
            w_nop   = 1'b1;
        end
    end

    assign w_issue = bus.decode_valid && !w_stall && !bus.branch_taken_execute;

    // Execute result is younger than memory result, so it wins when both match.
    always_comb begin
        w_fwd_a_next = 2'b00;
        w_fwd_b_next = 2'b00;
        if (w_issue) begin
            if (w_m1_ex && bus.wre_execute)       w_fwd_a_next = 2'b01;
            else if (w_m1_mem && bus.wre_memory)  w_fwd_a_next = 2'b10;
            if (w_m2_ex && bus.wre_execute)       w_fwd_b_next = 2'b01;
            else if (w_m2_mem && bus.wre_memory)  w_fwd_b_next = 2'b10;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vec_cnt      <= '0;
            r_vec_rd       <= '0;
            r_fwd_a        <= 2'b00;
            r_fwd_b        <= 2'b00;
            r_stall_cycles <= '0;
        end else begin
            if (w_issue && bus.vector_op_decode) begin
                r_vec_cnt <= VW'(VEC_LATENCY);
                r_vec_rd  <= bus.rd_decode;
            end else if (w_vec_busy) begin
                r_vec_cnt <= r_vec_cnt - VW'(1);
            end
            r_fwd_a <= w_fwd_a_next;
            r_fwd_b <= w_fwd_b_next;
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.stall_fetch    = w_stall;
    assign bus.stall_decode   = w_stall;
    assign bus.nop_mux_select = w_nop;
    assign bus.flush_decode   = w_flush;
    assign bus.forwardA_sel   = r_fwd_a;
    assign bus.forwardB_sel   = r_fwd_b;
    assign bus.vec_busy       = w_vec_busy;
    assign bus.stall_cycles   = r_stall_cycles;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scenario bench for hazard_control_unit: expected forwarding selects are queued
// when a decode cycle is driven and compared once the Decode/Execute edge has passed.
module tb_hazard_control_unit;
    localparam int CNT_W       = 10;
    localparam int VEC_LATENCY = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(.VEC_LATENCY(VEC_LATENCY), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] fwd_q[$];

    task automatic set_dec(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic u1, input logic u2, input logic [3:0] rd,
                           input logic wre, input logic vop);
        bus.decode_valid     = v;
        bus.rs1_decode       = rs1;
        bus.rs2_decode       = rs2;
        bus.uses_rs1_decode  = u1;
        bus.uses_rs2_decode  = u2;
        bus.rd_decode        = rd;
        bus.wre_decode       = wre;
        bus.vector_op_decode = vop;
    endtask

    task automatic set_pipe(input logic [3:0] rd_ex, input logic wre_ex, input logic ld,
                            input logic [3:0] rd_mem, input logic wre_mem, input logic br);
        bus.rd_execute           = rd_ex;
        bus.wre_execute          = wre_ex;
        bus.load_instruction     = ld;
        bus.rd_memory            = rd_mem;
        bus.wre_memory           = wre_mem;
        bus.branch_taken_execute = br;
    endtask

    // One decode cycle: control outputs checked now, selects queued and checked after the edge.
    task automatic run_cycle(input string name, input logic e_stall, input logic e_nop,
                             input logic e_flush, input logic [1:0] e_fa, input logic [1:0] e_fb);
        logic [3:0] exp_fwd;
        logic [3:0] got_ctl;
        #1;
        got_ctl = {bus.stall_fetch, bus.stall_decode, bus.nop_mux_select, bus.flush_decode};
        checks++;
        if (got_ctl !== {e_stall, e_stall, e_nop, e_flush}) begin
            errors++;
            $display("FAIL %s ctrl(sf,sd,nop,flush) got %b expected %b", name, got_ctl,
                     {e_stall, e_stall, e_nop, e_flush});
        end
        fwd_q.push_back({e_fa, e_fb});
        @(posedge clk);
        #1;
        exp_fwd = fwd_q.pop_front();
        checks++;
        if ({bus.forwardA_sel, bus.forwardB_sel} !== exp_fwd) begin
            errors++;
            $display("FAIL %s fwd(A,B) got %b expected %b", name,
                     {bus.forwardA_sel, bus.forwardB_sel}, exp_fwd);
        end
    endtask

    task automatic expect_busy(input string name, input logic e);
        checks++;
        if (bus.vec_busy !== e) begin
            errors++;
            $display("FAIL %s vec_busy got %b expected %b", name, bus.vec_busy, e);
        end
    endtask

    task automatic expect_cnt(input string name, input logic [CNT_W-1:0] e);
        checks++;
        if (bus.stall_cycles !== e) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d expected %0d", name, bus.stall_cycles, e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_pipe(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        set_dec(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.stall_fetch, bus.stall_decode, bus.nop_mux_select, bus.flush_decode} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0010",
                     {bus.stall_fetch, bus.stall_decode, bus.nop_mux_select, bus.flush_decode});
        end
        checks++;
        if ({bus.forwardA_sel, bus.forwardB_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fwd got %b expected 0000", {bus.forwardA_sel, bus.forwardB_sel});
        end
        expect_busy("reset", 1'b0);
        expect_cnt("reset", '0);
        reset = 1'b1;
        set_pipe(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        set_dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        set_pipe(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        set_dec(1'b1, 4'd3, 4'd1, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
        run_cycle("load_use_bubble", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        expect_cnt("load_use", CNT_W'(1));
        set_pipe(4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
        run_cycle("load_use_issue", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    endtask

    task automatic test_forwarding();
        set_pipe(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        set_dec(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        run_cycle("fwd_exec_b", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
        set_pipe(4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
        run_cycle("fwd_exec_beats_mem", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
        set_pipe(4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        run_cycle("fwd_mem_b_exec_nowre", 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        set_pipe(4'd2, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
        set_dec(1'b1, 4'd9, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        run_cycle("fwd_a_mem_b_exec", 1'b0, 1'b0, 1'b0, 2'b10, 2'b01);
        set_dec(1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
        run_cycle("fwd_unused_srcs", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_dec(1'b0, 4'd9, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        run_cycle("fwd_invalid", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_pipe(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_vector();
        set_dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        run_cycle("vec_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_dec(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < VEC_LATENCY; i++) begin
            expect_busy("vec_raw_stall", 1'b1);
            run_cycle("vec_raw_stall", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        end
        expect_busy("vec_raw_release", 1'b0);
        run_cycle("vec_raw_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1);
        run_cycle("vec2_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1);
        for (int i = 0; i < VEC_LATENCY; i++)
            run_cycle("vec_struct_stall", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        run_cycle("vec_struct_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        expect_busy("vec_struct_issued", 1'b1);
        set_dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < VEC_LATENCY; i++)
            run_cycle("vec_drain", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        expect_busy("vec_drained", 1'b0);
    endtask

    task automatic test_branch_flush();
        set_dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1);
        run_cycle("br_vec_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_pipe(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        set_dec(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b0);
        run_cycle("br_flush_over_load", 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
        expect_busy("br_vec_kept", 1'b1);
        set_pipe(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        set_dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        run_cycle("br_after1", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        run_cycle("br_after2", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        expect_busy("br_cnt_1", 1'b1);
        run_cycle("br_after3", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        expect_busy("br_cnt_0", 1'b0);
    endtask

    task automatic test_reset_mid_stall();
        set_dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1);
        run_cycle("rst_vec_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_dec(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0);
        run_cycle("rst_vec_stall", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.stall_fetch, bus.stall_decode, bus.nop_mux_select, bus.flush_decode} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_ctrl got %b expected 0010",
                     {bus.stall_fetch, bus.stall_decode, bus.nop_mux_select, bus.flush_decode});
        end
        @(posedge clk);
        #1;
        expect_busy("rst_mid", 1'b0);
        expect_cnt("rst_mid", '0);
        checks++;
        if ({bus.forwardA_sel, bus.forwardB_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_fwd got %b expected 0000", {bus.forwardA_sel, bus.forwardB_sel});
        end
        reset = 1'b1;
        set_dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        set_pipe(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        set_dec(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        repeat ((1 << CNT_W) - 2) @(posedge clk);
        #1;
        expect_cnt("sat_below", CNT_W'((1 << CNT_W) - 2));
        @(posedge clk);
        #1;
        expect_cnt("sat_reach", '1);
        repeat (6) @(posedge clk);
        #1;
        expect_cnt("sat_hold", '1);
        set_pipe(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        set_dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_vector();
        test_branch_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
